// File: rtl/alu_bist_driver.sv
// alu_bist_driver: power-on/diagnostic self-test initiator for the 32-bit ALU.
// Define ALU_BIST_LFSR_EN to append LFSR-generated operand pairs to the fixed set.
module alu_bist_driver #(
   parameter int SETTLE_CYC  = 1,
   parameter int ERR_W       = 8,
   parameter int LFSR_ROUNDS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [2:0]       fail_op,
   output logic [4:0]       fail_idx,
   output logic [31:0]      A,
   output logic [31:0]      B,
   output logic [2:0]       ALU_operation,
   input  logic [31:0]      res,
   input  logic             zero,
   input  logic             overflow
);

   typedef enum logic [2:0] {
      S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE
   } state_t;

`ifdef ALU_BIST_LFSR_EN
   localparam int NPAIR = 2 + LFSR_ROUNDS;
`else
   localparam int NPAIR = 2 + (LFSR_ROUNDS & 0);
`endif
   localparam int PW = (NPAIR > 4) ? $clog2(NPAIR) : 2;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [PW-1:0] LAST_PAIR = PW'(NPAIR - 1);
   localparam logic [SW-1:0] LAST_SET  = SW'(SETTLE_CYC - 1);

   state_t          state;
   logic [PW-1:0]   pair_q;
   logic [2:0]      op_q;
   logic [SW-1:0]   set_cnt;
   logic [31:0]     vec_a;
   logic [31:0]     vec_b;
   logic [31:0]     g_sum;
   logic [31:0]     g_dif;
   logic [31:0]     g_res;
   logic            g_ovf;
   logic            mismatch;
   logic            last_vec;
   logic [ERR_W-1:0] err_nxt;

`ifdef ALU_BIST_LFSR_EN
   localparam logic [31:0] SEED = 32'hACE1_0001;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   logic [31:0] lfsr_q;
   logic [31:0] lfsr_n1;
   logic [31:0] lfsr_n2;

   assign lfsr_n1 = lfsr_step(lfsr_q);
   assign lfsr_n2 = lfsr_step(lfsr_n1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else if (state == S_IDLE && start) begin
         lfsr_q <= SEED;
      end else if (state == S_CHECK && op_q == 3'd7 &&
                   pair_q >= PW'(2)) begin
         lfsr_q <= lfsr_n2;
      end
   end
`endif

   always_comb begin
      vec_a = 32'hA5A5_A5A5;
      vec_b = 32'h5A5A_5A5A;
      if (pair_q == PW'(1)) begin
         vec_a = 32'h0123_4567;
         vec_b = 32'h7654_3210;
      end
`ifdef ALU_BIST_LFSR_EN
      else if (pair_q != '0) begin
         vec_a = lfsr_q;
         vec_b = lfsr_n1;
      end
`endif
   end

   assign g_sum = A + B;
   assign g_dif = A - B;

   always_comb begin
      g_res = '0;
      g_ovf = 1'b0;
      case (ALU_operation)
         3'b000: g_res = A & B;
         3'b001: g_res = A | B;
         3'b010: begin
            g_res = g_sum;
            g_ovf = (A[31] == B[31]) && (g_sum[31] != A[31]);
         end
         3'b011: g_res = A ^ B;
         3'b100: g_res = ~(A | B);
         3'b101: g_res = A >> B[4:0];
         3'b110: begin
            g_res = g_dif;
            g_ovf = (A[31] != B[31]) && (g_dif[31] != A[31]);
         end
         default: g_res = {31'd0, $signed(A) < $signed(B)};
      endcase
   end

   assign mismatch = (res != g_res) || (zero != (g_res == '0)) ||
                     (overflow != g_ovf);
   assign last_vec = (op_q == 3'd7) && (pair_q == LAST_PAIR);
   assign err_nxt  = (mismatch && !(&err_cnt)) ? err_cnt + 1'b1 : err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         pair_q        <= '0;
         op_q          <= '0;
         set_cnt       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_cnt       <= '0;
         fail_op       <= '0;
         fail_idx      <= '0;
         A             <= '0;
         B             <= '0;
         ALU_operation <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_DRIVE;
                  busy     <= 1'b1;
                  pass     <= 1'b0;
                  err_cnt  <= '0;
                  fail_op  <= '0;
                  fail_idx <= '0;
                  pair_q   <= '0;
                  op_q     <= '0;
               end
            end
            S_DRIVE: begin
               A             <= vec_a;
               B             <= vec_b;
               ALU_operation <= op_q;
               set_cnt       <= '0;
               state         <= S_SETTLE;
            end
            S_SETTLE: begin
               if (set_cnt == LAST_SET) state <= S_CHECK;
               else set_cnt <= set_cnt + 1'b1;
            end
            S_CHECK: begin
               err_cnt <= err_nxt;
               if (mismatch && err_cnt == '0) begin
                  fail_op  <= op_q;
                  fail_idx <= {pair_q[1:0], op_q};
               end
               op_q <= op_q + 3'd1;
               if (op_q == 3'd7) pair_q <= pair_q + 1'b1;
               if (last_vec) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  pass  <= (err_nxt == '0);
               end else begin
                  state <= S_DRIVE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
